conv_tensor_serializer: RTL and testbench

- Consumer at the output end of the conv2 layer.
- Captures one flat 8x8 Float8 result tensor plus its overflow flag in a single cycle, then streams the 64 bytes one per beat over a valid/ready byte interface.
- Feeds the next stage: pooling, DMA or UART readout.
- Float8 values are opaque bytes here; no arithmetic is performed on them.

---
 rtl/conv_tensor_serializer.sv | 89 ++++++++
 tb/tb_conv_tensor_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/conv_tensor_serializer.sv
// Captures one flat ROWSxCOLS tensor of DW-bit elements in a single cycle and
// streams it out one element per valid/ready beat in row-major order.
module conv_tensor_serializer #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = 8,
    localparam int N   = ROWS * COLS,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [N*DW-1:0] tensor_in,
    input  logic            overflow_in,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic [IW-1:0]   out_index,
    output logic            busy,
    output logic            overflow_flag
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   nxt_idx;
    logic [DW-1:0]   shadow [N];

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    always_comb begin
        nxt_idx = idx + IW'(1);
    end

    assign out_index = idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            load_ready    <= 1'b1;
            overflow_flag <= 1'b0;
            for (int unsigned i = 0; i < N; i++) shadow[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        for (int unsigned i = 0; i < N; i++) shadow[i] <= tensor_in[i*DW +: DW];
                        overflow_flag <= overflow_in;
                        idx           <= '0;
                        // First beat comes straight from the input so it is valid the next cycle.
                        out_data      <= tensor_in[DW-1:0];
                        out_last      <= (N == 1);
                        out_valid     <= 1'b1;
                        busy          <= 1'b1;
                        load_ready    <= 1'b0;
                        state         <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            state      <= IDLE;
                            idx        <= '0;
                            out_data   <= '0;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                        end else begin
                            idx      <= nxt_idx;
                            out_data <= shadow[nxt_idx];
                            out_last <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tensor_serializer.sv
// Directed self-checking bench for conv_tensor_serializer: reset, streaming,
// backpressure, ignored loads while busy, back-to-back loads, mid-stream reset.
module tb_conv_tensor_serializer;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int N    = ROWS * COLS;
    localparam int IW   = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            load_valid;
    logic            load_ready;
    logic [N*DW-1:0] tensor_in;
    logic            overflow_in;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [IW-1:0]   out_index;
    logic            busy;
    logic            overflow_flag;

    int n_cmp = 0;
    int n_err = 0;

    conv_tensor_serializer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready),
        .tensor_in(tensor_in), .overflow_in(overflow_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_index(out_index),
        .busy(busy), .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind 0: element k = k+1; kind 1: all 0xA5; kind 2: all 0xFF
    function automatic logic [7:0] elem(input int kind, input int k);
        case (kind)
            0: return 8'(k + 1);
            1: return 8'hA5;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [N*DW-1:0] make_tensor(input int kind);
        logic [N*DW-1:0] t;
        for (int k = 0; k < N; k++) t[k*DW +: DW] = elem(kind, k);
        return t;
    endfunction

    task automatic check_idle(input string tag, input logic ovf);
        check({tag, ".valid"}, 64'(out_valid), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".load_ready"}, 64'(load_ready), 64'd1);
        check({tag, ".data"}, 64'(out_data), 64'd0);
        check({tag, ".ovf"}, 64'(overflow_flag), 64'(ovf));
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first beat.
    task automatic load(input int kind, input logic ovf);
        tensor_in   = make_tensor(kind);
        overflow_in = ovf;
        load_valid  = 1'b1;
        @(negedge clk);
        load_valid  = 1'b0;
    endtask

    // Called at a negedge with beat 0 presented. pat 0: ready always; pat 1: 1,0,0,1.
    // Stops after nbeats transfers. poke!=0 pulses a junk load during the stream.
    task automatic drain(input string tag, input int kind, input int pat, input int nbeats,
                         input bit poke);
        int  k = 0;
        int  cyc = 0;
        bit  rdy;
        while (k < nbeats && cyc < 1000) begin
            case (cyc % 4)
                0, 3:    rdy = 1'b1;
                default: rdy = (pat == 0);
            endcase
            out_ready = rdy;
            if (poke && cyc == 5) begin
                tensor_in  = make_tensor(2);
                load_valid = 1'b1;
            end
            if (poke && cyc == 7) load_valid = 1'b0;
            check({tag, ".valid"}, 64'(out_valid), 64'd1);
            check({tag, ".data"}, 64'(out_data), 64'(elem(kind, k)));
            check({tag, ".index"}, 64'(out_index), 64'(k));
            check({tag, ".last"}, 64'(out_last), 64'(k == N - 1));
            check({tag, ".busy"}, 64'(busy), 64'd1);
            check({tag, ".load_ready"}, 64'(load_ready), 64'd0);
            if (rdy) k++;
            @(negedge clk);
            cyc++;
        end
        check({tag, ".beats_in_budget"}, 64'(k), 64'(nbeats));
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        load_valid  = 1'b1;
        tensor_in   = make_tensor(0);
        overflow_in = 1'b1;
        out_ready   = 1'b1;

        // Reset with load_valid asserted: nothing may be captured.
        repeat (2) @(negedge clk);
        check_idle("reset_during", 1'b0);
        rst_n      = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        check_idle("reset_after", 1'b0);
        check("reset_after.index", 64'(out_index), 64'd0);
        check("reset_after.last", 64'(out_last), 64'd0);

        // Basic stream with out_ready held high; 64 beats then IDLE.
        load(0, 1'b1);
        check("basic.ovf", 64'(overflow_flag), 64'd1);
        drain("basic", 0, 0, N, 1'b0);
        check_idle("basic_end", 1'b1);

        // Backpressure 1,0,0,1 with a junk load pulsed mid-stream.
        @(negedge clk);
        load(0, 1'b1);
        drain("bp", 0, 1, N, 1'b1);
        check_idle("bp_end", 1'b1);
        @(negedge clk);
        check_idle("bp_no_second", 1'b1);

        // Back-to-back: second tensor waiting with load_valid held.
        load(0, 1'b1);
        tensor_in   = make_tensor(1);
        overflow_in = 1'b0;
        load_valid  = 1'b1;
        drain("b2b_first", 0, 0, N, 1'b0);
        check_idle("b2b_gap", 1'b1);
        @(negedge clk);
        load_valid = 1'b0;
        check("b2b.ovf", 64'(overflow_flag), 64'd0);
        drain("b2b_second", 1, 0, N, 1'b0);
        check_idle("b2b_end", 1'b0);

        // Mid-stream reset after 10 beats, then a fresh tensor from index 0.
        load(0, 1'b1);
        drain("mid_pre", 0, 0, 10, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("mid_reset", 1'b0);
        check("mid_reset.index", 64'(out_index), 64'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("mid_idle", 1'b0);
        end
        load(1, 1'b1);
        check("mid_new.ovf", 64'(overflow_flag), 64'd1);
        drain("mid_new", 1, 0, N, 1'b0);
        check_idle("mid_new_end", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
